// File: rtl/alu_issue_queue_if.sv
// Handshake and ALU-drive bundle between the issue queue and its surroundings.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Optional macro ALU_ISSUE_ZERO_FLAG_EN adds the out_zero signal.
interface alu_issue_queue_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [CTRL_W-1:0] in_ctrl;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_q;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_q;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  count;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic              out_zero;
`endif

    // Issue-queue side.
    modport slave (
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        output out_zero,
`endif
        input  in_valid, in_a, in_b, in_ctrl, alu_q, out_ready,
        output in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_q, out_ctrl, count
    );

    // Producer / ALU / consumer side.
    modport master (
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        input  out_zero,
`endif
        output in_valid, in_a, in_b, in_ctrl, alu_q, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_q, out_ctrl, count
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Buffers ALU requests in a FIFO, issues one at a time to the ALU and registers its result.
// Latency: push at edge N, pop at N+1, out_valid high after N+2; one result per 2 cycles.
// Backpressure: in_ready = (count < DEPTH) only; result held stable while out_valid && !out_ready.
// Optional macro ALU_ISSUE_ZERO_FLAG_EN adds a registered out_zero flag.
module alu_issue_queue #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_queue_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int ENT_W = CTRL_W + 2 * WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_r;
    logic [1:0]        state;
    logic [WIDTH-1:0]  alu_a_r;
    logic [WIDTH-1:0]  alu_b_r;
    logic [CTRL_W-1:0] alu_ctrl_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_q_r;
    logic [CTRL_W-1:0] out_ctrl_r;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    // in_ready looks only at the registered count, so a full FIFO refuses a push even while popping.
    assign bus.in_ready = (count_r < FULL);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (count_r != '0) &&
                          ((state == IDLE) || ((state == HOLD) && bus.out_ready));
    assign head         = mem[rd_ptr];

    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_ctrl  = alu_ctrl_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_q     = out_q_r;
    assign bus.out_ctrl  = out_ctrl_r;
    assign bus.count     = count_r;

    // FIFO storage: written on push, contents are don't-care until pushed so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_ctrl, bus.in_b, bus.in_a};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM: load ALU operands on pop, capture the settled ALU result one cycle later, hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            alu_ctrl_r  <= '0;
            out_valid_r <= 1'b0;
            out_q_r     <= '0;
            out_ctrl_r  <= '0;
        end else begin
            if (pop) begin
                alu_a_r    <= head[WIDTH-1:0];
                alu_b_r    <= head[2*WIDTH-1:WIDTH];
                alu_ctrl_r <= head[ENT_W-1:2*WIDTH];
            end
            case (state)
                IDLE: begin
                    if (pop) state <= ISSUE;
                end
                ISSUE: begin
                    out_q_r     <= bus.alu_q;
                    out_ctrl_r  <= alu_ctrl_r;
                    out_valid_r <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= pop ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic out_zero_r;
    assign bus.out_zero = out_zero_r;

    // Zero flag is captured in the same cycle as out_q so the two always describe the same result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero_r <= 1'b0;
        end else if (state == ISSUE) begin
            out_zero_r <= (bus.alu_q == '0);
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
    localparam int WIDTH  = 32;
    localparam int CTRL_W = 3;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [WIDTH-1:0]  q;
        logic              zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_queue_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) bus ();

    alu_issue_queue #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   acc_cyc[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    exp_t mon_e;
    logic done_flag;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [CTRL_W-1:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return '0;
        endcase
    endfunction

    // Behavioural stand-in for the team ALU.
    always_comb bus.alu_q = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);

    // Result monitor: a transfer happens at the next rising edge when valid && ready here.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_result got q=%h ctrl=%0d, scoreboard empty", bus.out_q, bus.out_ctrl);
            end else begin
                mon_e = sb.pop_front();
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                if (bus.out_q !== mon_e.q || bus.out_ctrl !== mon_e.ctrl || bus.out_zero !== mon_e.zero)
                    $display("FAIL result got q=%h ctrl=%0d zero=%b, want q=%h ctrl=%0d zero=%b",
                             bus.out_q, bus.out_ctrl, bus.out_zero, mon_e.q, mon_e.ctrl, mon_e.zero);
`else
                if (bus.out_q !== mon_e.q || bus.out_ctrl !== mon_e.ctrl)
                    $display("FAIL result got q=%h ctrl=%0d, want q=%h ctrl=%0d",
                             bus.out_q, bus.out_ctrl, mon_e.q, mon_e.ctrl);
`endif
                else passes++;
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [CTRL_W-1:0] c);
        int   n = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_ctrl  = c;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL send_timeout in_ready stayed %b, want 1", bus.in_ready);
        end else begin
            @(posedge clk);
            e.ctrl = c;
            e.q    = alu_fn(a, b, c);
            e.zero = (e.q == '0);
            sb.push_back(e);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid !== 1'b0) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (n >= budget) begin
            checks++;
            $display("FAIL drain_timeout pending=%0d out_valid=%b, want 0 and 0", sb.size(), bus.out_valid);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_flag && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (n >= budget) begin
            checks++;
            $display("FAIL producer_timeout producer did not finish within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_q !== '0 || bus.out_ctrl !== '0)
            $display("FAIL %s_out got valid=%b q=%h ctrl=%0d, want 0/0/0", tag, bus.out_valid, bus.out_q, bus.out_ctrl);
        else passes++;
        checks++;
        if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_ctrl !== '0)
            $display("FAIL %s_alu got a=%h b=%h ctrl=%0d, want 0/0/0", tag, bus.alu_a, bus.alu_b, bus.alu_ctrl);
        else passes++;
        checks++;
        if (bus.count !== '0 || bus.in_ready !== 1'b1)
            $display("FAIL %s_fifo got count=%0d in_ready=%b, want 0/1", tag, bus.count, bus.in_ready);
        else passes++;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        checks++;
        if (bus.out_zero !== 1'b0) $display("FAIL %s_zero got %b, want 0", tag, bus.out_zero);
        else passes++;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'd8;
        bus.in_b      = 32'd5;
        bus.in_ctrl   = 3'b000;
        @(posedge clk);
        sb.push_back('{ctrl: 3'b000, q: 32'd13, zero: 1'b0});
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.count !== 3'd1 || bus.out_valid !== 1'b0)
            $display("FAIL single_push got count=%0d out_valid=%b, want 1/0", bus.count, bus.out_valid);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.alu_a !== 32'd8 || bus.alu_b !== 32'd5)
            $display("FAIL single_pop got count=%0d valid=%b a=%0d b=%0d, want 0/0/8/5",
                     bus.count, bus.out_valid, bus.alu_a, bus.alu_b);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_q !== 32'd13 || bus.out_ctrl !== 3'b000)
            $display("FAIL single_latency got valid=%b q=%0d ctrl=%0d, want 1/13/0", bus.out_valid, bus.out_q, bus.out_ctrl);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0)
            $display("FAIL single_done got valid=%b count=%0d, want 0/0", bus.out_valid, bus.count);
        else passes++;
    endtask

    task automatic test_burst();
        bus.out_ready = 1'b1;
        acc_cyc.delete();
        for (int i = 0; i < 4; i++) send(32'd8, 32'd5, CTRL_W'(i));
        wait_drain(40);
        checks++;
        if (acc_cyc.size() !== 4) $display("FAIL burst_count got %0d results, want 4", acc_cyc.size());
        else passes++;
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 2)
                $display("FAIL burst_gap result %0d gap %0d cycles, want 2", i, acc_cyc[i] - acc_cyc[i-1]);
            else passes++;
        end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] held;
        bus.out_ready = 1'b0;
        done_flag     = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'(i * 7 + 100), 32'(i + 3), CTRL_W'(i % 4));
                done_flag = 1'b1;
            end
        join_none
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0)
            $display("FAIL full_level got count=%0d in_ready=%b, want 4/0", bus.count, bus.in_ready);
        else passes++;
        held = bus.out_q;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_q !== held || held !== 32'd103)
            $display("FAIL full_hold got valid=%b q=%0d (first seen %0d), want 1/103", bus.out_valid, bus.out_q, held);
        else passes++;
        bus.out_ready = 1'b1;
        wait_done(100);
        wait_drain(60);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.count !== 3'd0)
            $display("FAIL full_recover got in_ready=%b count=%0d, want 1/0", bus.in_ready, bus.count);
        else passes++;
    endtask

    task automatic test_wrap();
        int max_cnt = 0;
        int n = 0;
        bus.out_ready = 1'b1;
        done_flag     = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(32'($urandom), 32'($urandom), CTRL_W'($urandom_range(0, 3)));
                done_flag = 1'b1;
            end
        join_none
        while (!done_flag && n < 200) begin
            @(posedge clk); #1; n++;
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        end
        wait_done(10);
        wait_drain(60);
        checks++;
        if (max_cnt !== DEPTH) $display("FAIL wrap_peak got max count %0d, want %0d", max_cnt, DEPTH);
        else passes++;
        checks++;
        if (bus.count !== 3'd0) $display("FAIL wrap_empty got count=%0d, want 0", bus.count);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'(50 + i), 32'd1, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.count !== 3'd2 || bus.out_valid !== 1'b1)
            $display("FAIL midrst_setup got count=%0d valid=%b, want 2/1", bus.count, bus.out_valid);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0)
            $display("FAIL midrst_stale got valid=%b count=%0d, want 0/0", bus.out_valid, bus.count);
        else passes++;
    endtask

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    task automatic test_zero_flag();
        bus.out_ready = 1'b1;
        send(32'd8, 32'd8, 3'b001);
        send(32'd8, 32'd5, 3'b001);
        wait_drain(30);
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_ctrl   = '0;
        bus.out_ready = 1'b0;
        done_flag     = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_wrap();
        test_reset_mid();
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        test_zero_flag();
`endif
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
